// File: rtl/wb_mem_pkg.sv
// wb_mem_pkg: shared types, bus widths and address-split helpers for wb_mem_banks.
package wb_mem_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SELW = 4;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  function automatic logic [WB_AW-1:0] bank_of(input logic [WB_AW-1:0] off, input int lsb);
    return off >> lsb;
  endfunction
  function automatic logic [WB_AW-1:0] word_of(input logic [WB_AW-1:0] off, input int lsb);
    return (off & ((32'd1 << lsb) - 32'd1)) >> 2;
  endfunction
endpackage

// File: rtl/wb_mem_bank_sram.sv
// wb_mem_bank_sram: one byte-enabled single-port bank with registered read, optional extra output stage.
module wb_mem_bank_sram
  import wb_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int LAT = 1,
  parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [WB_SELW-1:0] sel,
  input  logic [AW-1:0]     addr,
  input  logic [WB_DW-1:0]  wdata,
  output logic [WB_DW-1:0]  rdata
);
  logic [WB_DW-1:0] mem [DEPTH];
  logic [WB_DW-1:0] q1, q2;
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SELW; i++)
      if (we && sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) q1 <= mem[addr];
    q2 <= q1;
  end
  assign rdata = (LAT == 2) ? q2 : q1;
endmodule

// File: rtl/wb_mem_banks.sv
// wb_mem_banks: Wishbone classic slave over N_BANKS SRAM banks with write protection and error responses.
module wb_mem_banks
  import wb_mem_pkg::*;
#(
  parameter int                 N_BANKS = 2,
  parameter int                 BANK_SIZE = 16384,
  parameter logic [WB_AW-1:0]   BASE_ADDR = 32'h0,
  parameter logic [N_BANKS-1:0] RO_MASK = 'b01,
  parameter int                 READ_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  input  logic               wp_disable_i,
  output logic               busy_o
);
  localparam int LSB = $clog2(BANK_SIZE);
  localparam int DEPTH = BANK_SIZE / 4;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam logic [32:0] TOTAL = 33'(N_BANKS) * 33'(BANK_SIZE);
  localparam logic [7:0] RO8 = 8'(RO_MASK);
  state_t state, state_n;
  logic [WB_AW-1:0] off;
  logic [BW-1:0] bank, bank_q;
  logic [AW-1:0] word;
  logic in_range, err_c, req, accept, err_q, we_q;
  logic [WB_DW-1:0] rd [N_BANKS];
  assign off = wb_adr_i - BASE_ADDR;
  assign bank = BW'(bank_of(off, LSB));
  assign word = AW'(word_of(off, LSB));
  assign in_range = (wb_adr_i >= BASE_ADDR) && ({1'b0, off} < TOTAL);
  assign err_c = !in_range || (wb_adr_i[1:0] != 2'b00) ||
                 (wb_we_i && RO8[3'(bank_of(off, LSB))] && !wp_disable_i);
  assign req = wb_cyc_i && wb_stb_i;
  // rst_i blocks the accept edge so a reset cycle can never commit a write
  assign accept = (state == IDLE) && req && !rst_i;
  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    wb_mem_bank_sram #(.DEPTH(DEPTH), .LAT(READ_LAT), .AW(AW)) u_sram (
      .clk(clk_i),
      .we(accept && wb_we_i && !err_c && (bank == BW'(g))),
      .re(accept && !wb_we_i && !err_c && (bank == BW'(g))),
      .sel(wb_sel_i),
      .addr(word),
      .wdata(wb_dat_i),
      .rdata(rd[g])
    );
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (req ? ((wb_we_i || err_c || READ_LAT == 1) ? RESP : RD_WAIT) : IDLE) :
              (state == RD_WAIT) ? (wb_cyc_i ? RESP : IDLE) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      err_q <= 1'b0;
      we_q <= 1'b0;
      bank_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        err_q <= err_c;
        we_q <= wb_we_i;
        bank_q <= bank;
      end
    end
  end
  assign wb_ack_o = (state == RESP) && !err_q;
  assign wb_err_o = (state == RESP) && err_q;
  assign wb_dat_o = (wb_ack_o && !we_q) ? rd[bank_q] : '0;
  assign busy_o = (state != IDLE);
endmodule

// File: tb/tb_wb_mem_banks.sv
// tb_wb_mem_banks: directed checks of wb_mem_banks at READ_LAT 1 and 2 sharing one stimulus bus.
module tb_wb_mem_banks;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0, wp = 0;
  logic [31:0] adr = 0, wdat = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat1, dat2;
  logic ack1, err1, busy1, ack2, err2, busy2;
  int n_chk = 0, n_err = 0;
  wb_mem_banks #(.READ_LAT(1)) d1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat1),
    .wb_ack_o(ack1), .wb_err_o(err1), .wp_disable_i(wp), .busy_o(busy1)
  );
  wb_mem_banks #(.READ_LAT(2)) d2 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat2),
    .wb_ack_o(ack2), .wb_err_o(err2), .wp_disable_i(wp), .busy_o(busy2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input bit l2, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat, output bit e);
    lat = 0;
    e = 0;
    rd = '0;
    @(posedge clk);
    #1 cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk);
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if ((l2 ? ack2 : ack1) || (l2 ? err2 : err1)) begin
        lat = i;
        e = l2 ? err2 : err1;
        rd = l2 ? dat2 : dat1;
        chk("ack_err_excl", {31'd0, l2 ? (ack2 & err2) : (ack1 & err1)}, 32'd0);
      end
    end
    @(posedge clk);
    #1 cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("post_resp_flags", {30'd0, l2 ? ack2 : ack1, l2 ? err2 : err1}, 32'd0);
    chk("post_resp_dat", l2 ? dat2 : dat1, 32'd0);
  endtask
  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit exp_e);
    logic [31:0] r;
    int lat;
    bit e;
    xfer(1'b0, 1'b1, a, d, s, r, lat, e);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
  endtask
  task automatic rd_chk(input string tag, input bit l2, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] exp_d, input int exp_lat, input bit exp_e);
    logic [31:0] r;
    int lat;
    bit e;
    xfer(l2, 1'b0, a, 32'h0, s, r, lat, e);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    if (!exp_e) chk({tag, "_dat"}, r, exp_d);
  endtask
  initial begin
    cyc = 1;
    stb = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_flags1", {29'd0, ack1, err1, busy1}, 32'd0);
      chk("rst_dat1", dat1, 32'd0);
      chk("rst_flags2", {29'd0, ack2, err2, busy2}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 0; cyc = 0; stb = 0;
    wr_chk("w_full", 32'h4000, 32'hDEADBEEF, 4'hF, 0);
    rd_chk("r_full", 0, 32'h4000, 4'hF, 32'hDEADBEEF, 1, 0);
    wr_chk("w_byte1", 32'h4000, 32'h0000AB00, 4'b0010, 0);
    rd_chk("r_byte1", 0, 32'h4000, 4'hF, 32'hDEADABEF, 1, 0);
    rd_chk("r_sel0", 0, 32'h4000, 4'h0, 32'hDEADABEF, 1, 0);
    wp = 1;
    wr_chk("w_ro_init", 32'h10, 32'hCAFEF00D, 4'hF, 0);
    wp = 0;
    wr_chk("w_prot", 32'h10, 32'h12345678, 4'hF, 1);
    rd_chk("r_prot", 0, 32'h10, 4'hF, 32'hCAFEF00D, 1, 0);
    wp = 1;
    wr_chk("w_unlock", 32'h10, 32'h12345678, 4'hF, 0);
    wp = 0;
    rd_chk("r_unlock", 0, 32'h10, 4'hF, 32'h12345678, 1, 0);
    rd_chk("r_oor", 0, 32'h8000, 4'hF, 32'h0, 1, 1);
    rd_chk("r_oor_top", 0, 32'hFFFFFFFC, 4'hF, 32'h0, 1, 1);
    wr_chk("w_mis", 32'h4002, 32'h11111111, 4'hF, 1);
    rd_chk("r_mis", 0, 32'h4001, 4'hF, 32'h0, 1, 1);
    rd_chk("r_after_mis", 0, 32'h4000, 4'hF, 32'hDEADABEF, 1, 0);
    rd_chk("r_lat2", 1, 32'h4000, 4'hF, 32'hDEADABEF, 2, 0);
    rd_chk("r_lat2_b0", 1, 32'h10, 4'hF, 32'h12345678, 2, 0);
    @(posedge clk);
    #1 cyc = 1; stb = 1; we = 0; adr = 32'h4000; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("rdwait_busy", {31'd0, busy2}, 32'd1);
    chk("rdwait_noack", {31'd0, ack2}, 32'd0);
    cyc = 0;
    stb = 0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_noack", {30'd0, ack2, err2}, 32'd0);
    end
    chk("drop_idle", {31'd0, busy2}, 32'd0);
    rd_chk("r_after_drop", 1, 32'h4000, 4'hF, 32'hDEADABEF, 2, 0);
    @(posedge clk);
    #1 cyc = 1; stb = 1; we = 0; adr = 32'h4000; sel = 4'hF;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; cyc = 0; stb = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdwait_noack", {29'd0, ack2, err2, busy2}, 32'd0);
    end
    rd_chk("r_after_rst", 1, 32'h4000, 4'hF, 32'hDEADABEF, 2, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_mem_banks.md
Name: wb_mem_banks

Overview:
- Parametrised Wishbone classic slave replacing the fixed pair of memory slaves on the SoC crossbar.
- Exposes N_BANKS contiguous, equally sized SRAM banks behind one crossbar port.
- Any bank can be marked write-protected (boot ROM), with a runtime unlock so the debug module can load it.
- Adds configurable read latency and error responses for out-of-range, misaligned and protected accesses.

Parameters:
- N_BANKS, 2, number of banks (1..8).
- BANK_SIZE, 16384, bytes per bank; power of two, at least 4.
- BASE_ADDR, 32'h0, byte address of bank 0; aligned to BANK_SIZE.
- RO_MASK, 'b01, N_BANKS bits; bit k=1 makes bank k write-protected.
- READ_LAT, 1, cycles from request accept to read ack (1 or 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer ack.
- wb_err_o  out  1  transfer error.
- wp_disable_i  in  1  1 = writes allowed to RO banks (driven by debug).
- busy_o  out  1  FSM not IDLE.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0, FSM=IDLE. Memory contents are not cleared.
- Address decode (combinational, in IDLE):
  - off = adr-BASE_ADDR (32-bit).
  - in_range = adr >= BASE_ADDR and off < N_BANKS*BANK_SIZE.
  - bank = off / BANK_SIZE.
  - word = off[log2(BANK_SIZE)-1:2].
  - misaligned = adr[1:0] != 0.
- Error condition: !in_range, or misaligned, or (we & RO_MASK[bank] & !wp_disable_i).
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - Accept when cyc&stb.
  - Error: go to RESP with err pending. Nothing written, memory untouched.
  - Write: bytes with sel=1 are committed on the accept edge. Go to RESP with ack pending.
  - Read: issue bank read on the accept edge. If READ_LAT=1 go to RESP; if READ_LAT=2 go to RD_WAIT.
- RD_WAIT: one cycle, then RESP. If cyc drops, go to IDLE and never assert ack.
- RESP: wb_ack_o or wb_err_o is high for exactly one cycle.
  - Read ack carries the bank data on wb_dat_o.
  - wb_dat_o returns to 0 on the next cycle.
  - Next state is IDLE.
  - If cyc dropped in the cycle before RESP, the response is suppressed.
- Latency: write or error ack 1 cycle after accept; read ack READ_LAT cycles after accept.
- Back-to-back requests with stb held: at most one transfer per READ_LAT+1 cycles. IDLE re-samples cyc/stb in the cycle after RESP.
- ack and err are never high together.
- busy_o = (state != IDLE).
- Simultaneous events:
  - rst_i has priority over everything. Reset mid-read drops the pending ack.
  - A write already committed by a reset-interrupted transfer stays committed.
- wp_disable_i is sampled only at accept; changing it mid-transfer has no effect on that transfer.
- Read of a sel=0000 request is treated as a normal full-word read. sel is ignored for reads.

Decomposition:
- Package wb_mem_pkg:
  - state enum (IDLE, RD_WAIT, RESP).
  - WB_DW=32, WB_AW=32, WB_SELW=4.
  - function clog2-based bank/word index extraction.
- Sub-module wb_mem_bank_sram:
  - Parameter DEPTH (words).
  - One bank of byte-enabled single-port RAM with a registered read port.
  - Optional second output register when READ_LAT=2.
  - Generated N_BANKS times. The bank output mux is driven by the registered bank index.

Test Plan (N_BANKS=2, BANK_SIZE=16384, BASE_ADDR=0, RO_MASK=01, READ_LAT=1 unless noted):
1. Hold rst_i=1 for 3 cycles with cyc=stb=1 -> ack=err=0, dat_o=0, busy_o=0 throughout.
2. Write 0x4000 <- 0xDEADBEEF, sel=1111 -> ack 1 cycle after accept. Then read 0x4000 -> ack 1 cycle after accept, dat_o=0xDEADBEEF.
3. Write 0x4000 <- 0x0000AB00, sel=0010, then read 0x4000 -> dat_o=0xDEADABEF.
4. Protected bank:
   - wp_disable_i=0, write 0x0010 <- 0x12345678 -> err for one cycle, no ack; read 0x0010 returns the prior value.
   - wp_disable_i=1, same write -> ack; read returns 0x12345678.
5. Out-of-range and misaligned:
   - Read 0x8000 -> err one cycle after accept.
   - Write 0x4002 -> err; read 0x4000 still returns 0xDEADABEF.
6. READ_LAT=2:
   - Read 0x4000 -> ack exactly 2 cycles after accept.
   - Repeat, dropping cyc the cycle after accept -> no ack; a following read of 0x4000 is served normally.
   - Repeat with rst_i=1 in RD_WAIT -> no ack; FSM is IDLE after reset.
